lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ISA_WIDTH, default 32, SHALL set the data and address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of bus cycles, counted in REQ+WAIT, before the access aborts.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid / in_ready, input / output, 1 each: request handshake from execute.
REQ-006 Ports mem_r_en and mem_w_en, inputs, 1 each: load and store request flags.
REQ-007 Port mem_addr, input, ISA_WIDTH: byte address.
REQ-008 Port mem_w, input, ISA_WIDTH: store data, zero-extended and right-justified.
REQ-009 Port mem_mask, input, 4: unshifted store mask (0001, 0011 or 1111).
REQ-010 Port ld_size, input, 2: load size (0 byte, 1 half, 2 word).
REQ-011 Port ld_unsigned, input, 1: load zero-extends when 1.
REQ-012 Bus request ports SHALL be bus_valid (output, 1), bus_ready (input, 1), bus_we (output, 1), bus_addr (output, ISA_WIDTH), bus_wdata (output, ISA_WIDTH) and bus_wstrb (output, 4).
REQ-013 Bus response ports SHALL be bus_rvalid (input, 1) and bus_rdata (input, ISA_WIDTH).
REQ-014 Result ports SHALL be out_valid (output, 1), out_ready (input, 1), out_rdata (output, ISA_WIDTH) and out_err (output, 1).

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, REQ, WAIT and DONE, with in_ready=1 only in IDLE.
REQ-016 In IDLE, on in_valid, the block SHALL latch all request inputs; the next state SHALL be DONE if either of the following holds:
- both mem_r_en and mem_w_en are 0 (err=0, rdata=0);
- an error condition holds (err=1).
Otherwise the next state SHALL be REQ.
REQ-017 Error conditions SHALL be:
- mem_r_en and mem_w_en both 1;
- a half access with addr[0]=1;
- a word access with addr[1:0]!=0;
- a store mask other than 0001, 0011 or 1111.
REQ-018 An errored access SHALL never assert bus_valid.
REQ-019 In REQ, the block SHALL hold bus_valid=1 and all bus_* outputs stable until bus_ready=1, then go to WAIT.
REQ-020 bus_addr SHALL be {addr[ISA_WIDTH-1:2],2'b00}.
REQ-021 bus_wstrb SHALL be mask<<addr[1:0].
REQ-022 bus_wdata SHALL be mem_w<<(8*addr[1:0]).
REQ-023 bus_we SHALL equal the latched mem_w_en.
REQ-024 In WAIT, bus_valid SHALL be 0; on bus_rvalid, the block SHALL capture bus_rdata and go to DONE; for stores, bus_rvalid is the write acknowledge and its data SHALL be ignored.
REQ-025 A bus_rvalid seen in REQ or in the same cycle as bus_ready SHALL be ignored; only WAIT consumes it.
REQ-026 Load extraction SHALL be as follows:
- shift captured data right by 8*addr[1:0];
- take 8, 16 or 32 bits per ld_size;
- sign-extend unless ld_unsigned=1;
- store results SHALL be out_rdata=0.
REQ-027 A cycle counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT; when it reaches TIMEOUT, the block SHALL go to DONE with err=1, deassert bus_valid, and ignore any later bus_rvalid.
REQ-028 In DONE, the block SHALL hold out_valid=1 with out_rdata and out_err stable until out_ready=1, then return to IDLE; minimum latency from an accepted request to out_valid SHALL be 1 cycle on the error/no-op path and 3 cycles with zero-wait bus.
REQ-029 Back-to-back requests: a new request SHALL be accepted no earlier than the cycle after the DONE handshake.

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-transaction, and the counter SHALL clear.
REQ-031 Reset values SHALL be:
- in_ready=1;
- bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0;
- out_valid=0, out_rdata=0, out_err=0.
REQ-032 After reset, a pending bus response SHALL be ignored.

Verification
REQ-033 sb: addr=0x8000_0003, mem_w=0xAB, mask=0001, bus_ready=1 immediate, rvalid next cycle -> bus_addr=0x8000_0000, wstrb=1000, wdata=0xAB00_0000, bus_we=1; out_valid 3 cycles after accept, out_err=0.
REQ-034 lh signed: addr=0x8000_0002, bus_rdata=0x8001_1234 -> out_rdata=0xFFFF_8001; same with lhu -> 0x0000_8001; lbu at addr offset 1 -> 0x0000_0012.
REQ-035 lw: addr=0x8000_0002 -> no bus_valid ever, out_valid next cycle with out_err=1; mem_r_en=mem_w_en=1 -> same response.
REQ-036 Backpressure: hold bus_ready=0 for 5 cycles -> bus_valid and bus_* outputs stable throughout; hold out_ready=0 for 4 cycles -> out_valid and out_rdata stable, in_ready=0.
REQ-037 Timeout: TIMEOUT=8, bus_rvalid never asserted -> out_err=1 after 8 REQ/WAIT cycles; a late bus_rvalid afterwards does not change outputs.
REQ-038 Reset in WAIT: assert rst for 1 cycle -> IDLE, out_valid=0, in_ready=1; a following bus_rvalid produces no out_valid.

Source files
------------

// File: rtl/lsu_ctrl.sv
`default_nettype none
//============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store unit controller. Accepts one memory request from
//            execute, checks alignment and mask legality, drives a single
//            word-aligned bus request and waits for its response. Load data
//            is shifted, sized and extended; the result is held until the
//            consumer accepts it. A cycle counter aborts a bus access that
//            does not complete within TIMEOUT cycles.
// Ports    :
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid / in_ready      - request handshake from execute
//   mem_r_en, mem_w_en       - load / store request flags
//   mem_addr, mem_w          - byte address, right-justified store data
//   mem_mask                 - unshifted store mask (0001, 0011, 1111)
//   ld_size, ld_unsigned     - load size (0 byte, 1 half, 2 word), zero-ext
//   bus_valid / bus_ready    - bus request handshake
//   bus_we, bus_addr         - write flag, word-aligned address
//   bus_wdata, bus_wstrb     - lane-aligned store data and byte strobes
//   bus_rvalid, bus_rdata    - bus response / write acknowledge
//   out_valid / out_ready    - result handshake
//   out_rdata, out_err       - extracted load data, error flag
// Revision : 1.0 - initial release
//============================================================================
module lsu_ctrl #(
    parameter int ISA_WIDTH = 32,   // data/address width, at least 32
    parameter int TIMEOUT   = 255   // max REQ+WAIT cycles before abort
) (
    input  logic                 clk,
    input  logic                 rst,
    // request from execute
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic [ISA_WIDTH-1:0] mem_addr,
    input  logic [ISA_WIDTH-1:0] mem_w,
    input  logic [3:0]           mem_mask,
    input  logic [1:0]           ld_size,
    input  logic                 ld_unsigned,
    // bus request
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_we,
    output logic [ISA_WIDTH-1:0] bus_addr,
    output logic [ISA_WIDTH-1:0] bus_wdata,
    output logic [3:0]           bus_wstrb,
    // bus response
    input  logic                 bus_rvalid,
    input  logic [ISA_WIDTH-1:0] bus_rdata,
    // result
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ISA_WIDTH-1:0] out_rdata,
    output logic                 out_err
);

    localparam int              c_CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [1:0]           r_off;
    logic [1:0]           r_ld_size;
    logic                 r_ld_uns;
    logic                 r_is_store;
    logic                 r_bus_we;
    logic [ISA_WIDTH-1:0] r_bus_addr;
    logic [ISA_WIDTH-1:0] r_bus_wdata;
    logic [3:0]           r_bus_wstrb;
    logic [ISA_WIDTH-1:0] r_out_rdata;
    logic                 r_out_err;

    //------------------------------------------------------------------------
    // Request decode. Access size comes from ld_size for loads and from the
    // mask for stores; ld_size=3 is treated as a word.
    //------------------------------------------------------------------------
    logic       w_is_half;
    logic       w_is_word;
    logic       w_bad_mask;
    logic       w_noop;
    logic       w_err;
    logic [1:0] w_off;

    assign w_off      = mem_addr[1:0];
    assign w_is_half  = mem_r_en ? (ld_size == 2'd1) : (mem_mask == 4'b0011);
    assign w_is_word  = mem_r_en ? ld_size[1]        : (mem_mask == 4'b1111);
    assign w_bad_mask = mem_w_en && (mem_mask != 4'b0001) &&
                        (mem_mask != 4'b0011) && (mem_mask != 4'b1111);
    assign w_noop     = !mem_r_en && !mem_w_en;
    assign w_err      = (mem_r_en && mem_w_en)       ||
                        (w_is_half && w_off[0])      ||
                        (w_is_word && (w_off != 2'd0)) ||
                        w_bad_mask;

    //------------------------------------------------------------------------
    // Load extraction from the live response word, using the latched
    // request attributes.
    //------------------------------------------------------------------------
    logic [ISA_WIDTH-1:0] w_rshift;
    logic [ISA_WIDTH-1:0] w_ld_data;

    assign w_rshift = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld_data = '0;
        case (r_ld_size)
            2'd0: w_ld_data = r_ld_uns ? ISA_WIDTH'(w_rshift[7:0])
                                       : ISA_WIDTH'($signed(w_rshift[7:0]));
            2'd1: w_ld_data = r_ld_uns ? ISA_WIDTH'(w_rshift[15:0])
                                       : ISA_WIDTH'($signed(w_rshift[15:0]));
            default: w_ld_data = r_ld_uns ? ISA_WIDTH'(w_rshift[31:0])
                                          : ISA_WIDTH'($signed(w_rshift[31:0]));
        endcase
    end

    logic [c_CW-1:0] w_cnt_next;
    logic            w_timeout;

    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (w_cnt_next == c_TIMEOUT);

    //------------------------------------------------------------------------
    // Control FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_off       <= 2'd0;
            r_ld_size   <= 2'd0;
            r_ld_uns    <= 1'b0;
            r_is_store  <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= 4'd0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_off       <= w_off;
                        r_ld_size   <= ld_size;
                        r_ld_uns    <= ld_unsigned;
                        r_is_store  <= mem_w_en;
                        r_bus_we    <= mem_w_en;
                        r_bus_addr  <= {mem_addr[ISA_WIDTH-1:2], 2'b00};
                        r_bus_wdata <= mem_w << {w_off, 3'b000};
                        r_bus_wstrb <= mem_mask << w_off;
                        r_out_rdata <= '0;
                        r_out_err   <= w_err;
                        r_cnt       <= '0;
                        r_state     <= (w_noop || w_err) ? c_ST_DONE : c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    // A response in REQ is never consumed; only WAIT takes it.
                    r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_out_err <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else if (bus_ready) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // A response arriving on the timeout cycle still completes
                    // the access normally.
                    if (bus_rvalid) begin
                        r_out_rdata <= r_is_store ? '0 : w_ld_data;
                        r_state     <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_out_err <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign bus_valid = (r_state == c_ST_REQ);
    assign out_valid = (r_state == c_ST_DONE);
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;
    assign out_rdata = r_out_rdata;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire
